// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
// hazard_ctrl: stall/flush/freeze sequencer for the 5-stage pipe.
// A per-register down-counter scoreboard tracks how many more cycles a
// consumer of each register must wait. Latency values must fit in CNT_W bits.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal issue; hazards stall, taken branches flush
// HALT  | HALT issued; front end held until reset, scoreboard drains
module hazard_ctrl #(
  parameter int NREGS    = 8,
  parameter int CNT_W    = 2,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [$clog2(NREGS)-1:0] id_rs,
  input  logic                     id_rs_used,
  input  logic [$clog2(NREGS)-1:0] id_rt,
  input  logic                     id_rt_used,
  input  logic [$clog2(NREGS)-1:0] id_write_sel,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_halt,
  input  logic                     ex_branch_taken,
  input  logic                     mem_busy,
  output logic                     pc_stall,
  output logic                     if_id_stall,
  output logic                     id_ex_bubble,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     pipe_freeze,
  output logic                     halted,
  output logic [15:0]              stall_count
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;
  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] ALU_V  = CNT_W'(ALU_LAT);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt [NREGS];
  logic [15:0]      r_stall_count;

  logic w_hz;
  logic w_issue;
  logic w_count;

  // Decode depends on a producer whose result cannot be forwarded yet.
  always_comb begin
    w_hz = id_valid & ((id_rs_used & (r_cnt[id_rs] != '0)) |
                       (id_rt_used & (r_cnt[id_rt] != '0)));
  end

  // Prioritised control decode: freeze > flush > halt > hazard > issue.
  // Outputs are forced low while reset is asserted, whatever the inputs do.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    w_issue      = 1'b0;
    w_count      = 1'b0;
    if (rst) begin
      if (mem_busy) begin
        pipe_freeze = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (r_state == HALT) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (w_hz) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
        w_count      = 1'b1;
      end else begin
        w_issue = id_valid;
      end
    end
  end

  // Scoreboard: drain every pending count, reload the issuing writer's entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else if (!mem_busy) begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_issue && id_reg_write && (id_write_sel == IDX_W'(r)))
          r_cnt[r] <= id_mem_read ? LOAD_V : ALU_V;
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  // RUN -> HALT once a HALT instruction actually issues; only reset leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= RUN;
    else if (!mem_busy && w_issue && id_halt)
      r_state <= HALT;
  end

  // Saturating count of hazard-stall cycles (flushes and halt do not count).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_count <= 16'h0000;
    else if (w_count && (r_stall_count != 16'hFFFF))
      r_stall_count <= r_stall_count + 16'h0001;
  end

  assign halted      = (r_state == HALT);
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
// Directed bench for hazard_ctrl: per-cycle vector table plus hand-written
// halt/reset sequences and a saturation run on a long-latency instance.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read, id_halt;
  logic [2:0] id_rs, id_rt, id_write_sel;
  logic ex_branch_taken, mem_busy;
  logic pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush, pipe_freeze, halted;
  logic [15:0] stall_count;
  logic s_pc_stall, s_if_id_stall, s_id_ex_bubble, s_if_id_flush, s_id_ex_flush, s_pipe_freeze, s_halted;
  logic [15:0] s_stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_write_sel(id_write_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_halt(id_halt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .halted(halted),
    .stall_count(stall_count)
  );

  // Long-latency instance: a self-dependent load stalls 15 of every 16 cycles.
  hazard_ctrl #(.NREGS(8), .CNT_W(4), .ALU_LAT(0), .LOAD_LAT(15)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_write_sel(id_write_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_halt(id_halt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .pc_stall(s_pc_stall),
    .if_id_stall(s_if_id_stall), .id_ex_bubble(s_id_ex_bubble), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .pipe_freeze(s_pipe_freeze), .halted(s_halted),
    .stall_count(s_stall_count)
  );

  typedef struct {
    logic       valid;
    logic [2:0] rs;
    logic       rs_used;
    logic [2:0] rt;
    logic       rt_used;
    logic [2:0] wsel;
    logic       rw;
    logic       mr;
    logic       halt;
    logic       br;
    logic       busy;
    logic [6:0] ctl;   // {pc_stall,if_id_stall,id_ex_bubble,if_id_flush,id_ex_flush,pipe_freeze,halted}
    logic [15:0] sc;
  } vec_t;

  localparam int NV = 27;
  vec_t tv [NV];

  function automatic vec_t mk(logic v, logic [2:0] rs, logic rsu, logic [2:0] rt, logic rtu,
                              logic [2:0] ws, logic rw, logic mr, logic h, logic br, logic bz,
                              logic [6:0] ctl, logic [15:0] sc);
    vec_t t;
    t.valid = v; t.rs = rs; t.rs_used = rsu; t.rt = rt; t.rt_used = rtu;
    t.wsel = ws; t.rw = rw; t.mr = mr; t.halt = h; t.br = br; t.busy = bz;
    t.ctl = ctl; t.sc = sc;
    return t;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush, pipe_freeze, halted};
  endfunction

  task automatic drive(vec_t t);
    id_valid = t.valid; id_rs = t.rs; id_rs_used = t.rs_used; id_rt = t.rt;
    id_rt_used = t.rt_used; id_write_sel = t.wsel; id_reg_write = t.rw;
    id_mem_read = t.mr; id_halt = t.halt; ex_branch_taken = t.br; mem_busy = t.busy;
  endtask

  task automatic chk(string name, logic [22:0] act, logic [22:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ctl=%b sc=%h, expected ctl=%b sc=%h",
               name, act[22:16], act[15:0], exp[22:16], exp[15:0]);
    end
  endtask

  // Drive one vector just after an edge, check mid-cycle, advance to next edge+1.
  task automatic step(string name, vec_t t);
    drive(t);
    #3;
    chk(name, {ctl_now(), stall_count}, {t.ctl, t.sc});
    @(posedge clk); #1;
  endtask

  initial begin
    // Table: default parameters (LOAD_LAT=1, ALU_LAT=0).
    tv[0]  = mk(0,0,0,0,0,0,0,0,0,0,0, 7'b0000000, 16'd0); // idle after reset
    tv[1]  = mk(1,0,0,0,0,3,1,1,0,0,0, 7'b0000000, 16'd0); // load R3
    tv[2]  = mk(1,3,1,0,0,0,0,0,0,0,0, 7'b1110000, 16'd0); // load-use stall
    tv[3]  = mk(1,3,1,0,0,0,0,0,0,0,0, 7'b0000000, 16'd1); // now issues
    tv[4]  = mk(1,0,0,0,0,5,1,0,0,0,0, 7'b0000000, 16'd1); // ALU writes R5
    tv[5]  = mk(1,0,0,5,1,0,0,0,0,0,0, 7'b0000000, 16'd1); // reader: no stall
    tv[6]  = mk(1,0,0,0,0,2,1,1,0,0,0, 7'b0000000, 16'd1); // load R2
    tv[7]  = mk(1,2,1,0,0,6,1,1,0,1,0, 7'b0001100, 16'd1); // branch beats hazard; squashed load R6
    tv[8]  = mk(1,6,1,2,1,0,0,0,0,0,0, 7'b0000000, 16'd1); // R6 never set, R2 drained
    tv[9]  = mk(1,0,0,0,0,4,1,1,0,0,0, 7'b0000000, 16'd1); // load R4
    tv[10] = mk(1,4,1,0,0,0,0,0,0,0,1, 7'b0000010, 16'd1); // freeze during stall
    tv[11] = mk(1,4,1,0,0,0,0,0,0,0,1, 7'b0000010, 16'd1);
    tv[12] = mk(1,4,1,0,0,0,0,0,0,0,1, 7'b0000010, 16'd1);
    tv[13] = mk(1,4,1,0,0,0,0,0,0,0,0, 7'b1110000, 16'd1); // one stall remains
    tv[14] = mk(1,4,1,0,0,0,0,0,0,0,0, 7'b0000000, 16'd2);
    tv[15] = mk(1,0,0,0,0,0,0,0,0,1,1, 7'b0000010, 16'd2); // freeze beats branch
    tv[16] = mk(1,0,0,0,0,7,1,1,0,0,0, 7'b0000000, 16'd2); // load R7
    tv[17] = mk(1,0,0,0,0,7,1,0,0,0,0, 7'b0000000, 16'd2); // ALU R7 overwrites count
    tv[18] = mk(1,7,1,0,0,0,0,0,0,0,0, 7'b0000000, 16'd2); // no stall
    tv[19] = mk(1,0,0,0,0,0,1,1,0,0,0, 7'b0000000, 16'd2); // load R0
    tv[20] = mk(1,0,0,0,1,0,0,0,0,0,0, 7'b1110000, 16'd2); // R0 tracked like any reg
    tv[21] = mk(1,0,0,0,1,0,0,0,0,0,0, 7'b0000000, 16'd3);
    tv[22] = mk(1,0,0,0,0,1,1,1,0,0,0, 7'b0000000, 16'd3); // load R1
    tv[23] = mk(1,1,0,0,0,0,0,0,0,0,0, 7'b0000000, 16'd3); // rs not used: no stall
    tv[24] = mk(1,0,0,0,0,1,1,1,0,0,0, 7'b0000000, 16'd3); // load R1
    tv[25] = mk(0,1,1,1,1,0,0,0,0,0,0, 7'b0000000, 16'd3); // bubble in decode: no stall
    tv[26] = mk(1,1,1,0,0,0,0,0,0,0,0, 7'b0000000, 16'd3); // R1 drained

    rst = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,1,1, 7'b0, 16'd0)); // busy/branch high during reset
    #2;
    chk("reset_outputs", {ctl_now(), stall_count}, 23'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) step($sformatf("vec%0d", i), tv[i]);

    // Halt: issues in RUN, halted from the next edge, front end held.
    step("halt_issue", mk(1,0,0,0,0,0,0,0,1,0,0, 7'b0000000, 16'd3));
    step("halted_1",   mk(1,0,1,0,0,0,0,0,0,0,0, 7'b1110001, 16'd3));
    step("halted_2",   mk(1,0,1,0,0,2,1,1,0,0,0, 7'b1110001, 16'd3));
    step("halted_br",  mk(1,0,0,0,0,0,0,0,0,1,0, 7'b0001101, 16'd3));
    step("halted_frz", mk(1,0,0,0,0,0,0,0,0,0,1, 7'b0000011, 16'd3));
    drive(mk(1,0,1,0,0,0,0,0,0,0,0, 7'b0, 16'd0));
    #1;
    chk("halted_3", {ctl_now(), stall_count}, {7'b1110001, 16'd3});
    #1 rst = 1'b0;
    #1;
    chk("halt_async_rst", {ctl_now(), stall_count}, 23'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    step("post_rst_run", mk(1,0,1,0,0,3,1,1,0,0,0, 7'b0000000, 16'd0)); // load R3
    drive(mk(1,3,1,0,0,0,0,0,0,0,0, 7'b0, 16'd0));
    #1;
    chk("stall_pre_rst", {ctl_now(), stall_count}, {7'b1110000, 16'd0});
    #1 rst = 1'b0;
    #1;
    chk("stall_async_rst", {ctl_now(), stall_count}, 23'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    step("post_rst_empty", mk(1,3,1,0,0,0,0,0,0,0,0, 7'b0000000, 16'd0));

    // Saturation: self-dependent load on the LOAD_LAT=15 instance.
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    drive(mk(1,1,1,0,0,1,1,1,0,0,0, 7'b0, 16'd0));
    repeat (70000) @(posedge clk);
    #1;
    n_cmp++;
    if (s_stall_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_count: got %h, expected ffff", s_stall_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
